// File: rtl/alert_arbiter.sv
// alert_arbiter: shares one active-low buzzer between N_REQ alert sources.
// Fixed priority, index 0 highest. Index 0 (emergency) preempts at any time,
// including during the silent gap. Every other owner keeps the buzzer for at
// least MIN_HOLD cycles, and a GAP_CYCLES silent gap separates owners that
// release normally. The current owner's class selects the beep pattern.
//
// Ports:
//   clk            system clock
//   reset_n        synchronous active-low reset
//   req            level requests, bit i = source i
//   grant          one-hot current owner, zero when silent
//   owner          index of current owner, 0 when no grant
//   busy           high in GRANT or GAP
//   preempt_pulse  one-cycle pulse when the owner changes without a gap
//   buzzer_pin     buzzer drive, active low (1 = silent)
//
// state   | meaning
// --------+-----------------------------------------------
// S_IDLE  | no requests, buzzer silent
// S_GRANT | owner holds the buzzer, pattern running
// S_GAP   | silent gap after an owner released
module alert_arbiter #(
  parameter int N_REQ       = 4,
  parameter int MIN_HOLD    = 5_000_000,
  parameter int GAP_CYCLES  = 500_000,
  parameter int PERIOD_FAST = 2_500_000,
  parameter int PERIOD_SLOW = 12_500_000
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [N_REQ-1:0]         req,
  output logic [N_REQ-1:0]         grant,
  output logic [$clog2(N_REQ)-1:0] owner,
  output logic                     busy,
  output logic                     preempt_pulse,
  output logic                     buzzer_pin
);

  localparam int OW    = $clog2(N_REQ);
  localparam int MAX_A = (MIN_HOLD > GAP_CYCLES) ? MIN_HOLD : GAP_CYCLES;
  localparam int MAX_B = (MAX_A > 2*PERIOD_SLOW) ? MAX_A : 2*PERIOD_SLOW;
  localparam int CW    = $clog2(MAX_B) + 1;

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_GAP} state_t;

  state_t          state_q, state_n;
  logic [OW-1:0]   owner_q, owner_n;
  logic [CW-1:0]   hold_q, hold_n;
  logic [CW-1:0]   gap_q, gap_n;
  logic [CW-1:0]   phase_q, phase_n;
  logic            pre_n;
  logic [OW-1:0]   hp;
  logic            req_any;
  logic            hold_done;
  logic            tone_n;
  logic [CW-1:0]   phase_wrap;

  // Owner 1 beeps fast; owners >= 2 beep slow. Owner 0 is steady, so its
  // period only bounds the phase counter.
  function automatic logic [CW-1:0] half_period(input logic [OW-1:0] o);
    return (o == OW'(1)) ? CW'(PERIOD_FAST) : CW'(PERIOD_SLOW);
  endfunction

  // Lowest set index wins; scanning downward leaves the lowest one last.
  always_comb begin
    hp = '0;
    for (int i = N_REQ-1; i >= 0; i--) begin
      if (req[i]) hp = OW'(i);
    end
  end

  assign req_any    = |req;
  assign hold_done  = (hold_q >= CW'(MIN_HOLD-1));
  assign phase_wrap = (half_period(owner_q) << 1) - CW'(1);

  always_comb begin
    state_n = state_q;
    owner_n = owner_q;
    hold_n  = hold_q;
    gap_n   = gap_q;
    phase_n = phase_q;
    pre_n   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_any) begin
          state_n = S_GRANT;
          owner_n = hp;
          hold_n  = '0;
          phase_n = '0;
        end
      end
      S_GRANT: begin
        if (req[0] && owner_q != '0) begin
          owner_n = '0;
          hold_n  = '0;
          phase_n = '0;
          pre_n   = 1'b1;
        end else if (hold_done && req_any && hp < owner_q) begin
          owner_n = hp;
          hold_n  = '0;
          phase_n = '0;
          pre_n   = 1'b1;
        end else if (hold_done && !req[owner_q]) begin
          state_n = S_GAP;
          owner_n = '0;
          hold_n  = '0;
          phase_n = '0;
          gap_n   = '0;
        end else begin
          hold_n  = (hold_q < CW'(MIN_HOLD)) ? hold_q + CW'(1) : hold_q;
          phase_n = (phase_q >= phase_wrap) ? '0 : phase_q + CW'(1);
        end
      end
      S_GAP: begin
        if (req[0]) begin
          state_n = S_GRANT;
          owner_n = '0;
          hold_n  = '0;
          phase_n = '0;
          gap_n   = '0;
        end else if (gap_q == CW'(GAP_CYCLES-1)) begin
          gap_n = '0;
          if (req_any) begin
            state_n = S_GRANT;
            owner_n = hp;
            hold_n  = '0;
            phase_n = '0;
          end else begin
            state_n = S_IDLE;
          end
        end else begin
          gap_n = gap_q + CW'(1);
        end
      end
      default: begin
        state_n = S_IDLE;
        owner_n = '0;
        hold_n  = '0;
        gap_n   = '0;
        phase_n = '0;
      end
    endcase
  end

  // Outputs are computed from next-state values so that grant, owner and the
  // buzzer all move on the same edge as the state change.
  assign tone_n = (owner_n == '0) || (phase_n < half_period(owner_n));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      owner_q       <= '0;
      hold_q        <= '0;
      gap_q         <= '0;
      phase_q       <= '0;
      grant         <= '0;
      owner         <= '0;
      busy          <= 1'b0;
      preempt_pulse <= 1'b0;
      buzzer_pin    <= 1'b1;
    end else begin
      state_q       <= state_n;
      owner_q       <= owner_n;
      hold_q        <= hold_n;
      gap_q         <= gap_n;
      phase_q       <= phase_n;
      grant         <= (state_n == S_GRANT) ? (N_REQ'(1) << owner_n) : '0;
      owner         <= (state_n == S_GRANT) ? owner_n : '0;
      busy          <= (state_n != S_IDLE);
      preempt_pulse <= pre_n;
      buzzer_pin    <= (state_n == S_GRANT) ? ~tone_n : 1'b1;
    end
  end

endmodule

// File: doc/alert_arbiter.md
Name: alert_arbiter

Overview:
Shares the single active-low buzzer between up to N_REQ alert sources, e.g. emergency, doorbell, reminder and fault. Fixed priority applies, with index 0 the highest. Index 0 (emergency) may preempt at any time. Every other source gets a guaranteed minimum audible hold and a silent gap between owners. The block sits between the house subsystems' alarm requests and the buzzer pin, and generates a per-class beep pattern for the current owner.

Parameters:
N_REQ, 4, number of requesters (2..8); index 0 = emergency.
MIN_HOLD, 5_000_000, minimum cycles a grant is held (~100 ms @ 50 MHz).
GAP_CYCLES, 500_000, silent cycles between successive owners (~10 ms).
PERIOD_FAST, 2_500_000, half-period of the owner-1 beep pattern.
PERIOD_SLOW, 12_500_000, half-period of the beep pattern for owners >= 2.

Ports:
clk  in  1  system clock, 50 MHz.
reset_n  in  1  synchronous active-low reset.
req  in  N_REQ  level requests, active high, bit i = source i.
grant  out  N_REQ  one-hot current owner; all zero when silent.
owner  out  $clog2(N_REQ)  index of current owner; 0 when no grant.
busy  out  1  high in GRANT or GAP.
preempt_pulse  out  1  one-cycle pulse when the owner changes without a gap.
buzzer_pin  out  1  buzzer drive, active low (1 = silent).

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-low on reset_n. All state changes on posedge clk. All outputs are registered.
- Reset (reset_n=0 at an edge): state=IDLE, grant=0, owner=0, busy=0, preempt_pulse=0, buzzer_pin=1, hold/gap/phase counters=0.
  - This applies mid-grant as well: the buzzer is silenced on the same edge.
- Priority select: hp = lowest set index of req.
- States: IDLE, GRANT, GAP.
- IDLE:
  - If req != 0, go to GRANT on the next edge with owner=hp, hold_cnt=0, phase_cnt=0.
  - Latency: req rises at edge k; grant and buzzer_pin update at edge k+1.
- GRANT, hold counter:
  - hold_cnt increments each cycle and saturates at MIN_HOLD.
  - hold_done = (hold_cnt >= MIN_HOLD-1).
- GRANT, transitions, priority order:
  1. req[0]=1 and owner!=0 -> owner=0, hold_cnt=0, phase_cnt=0, preempt_pulse=1, stay in GRANT. This ignores hold_done.
  2. hold_done and hp < owner (higher priority pending) -> owner=hp, counters cleared, preempt_pulse=1, no gap.
  3. hold_done and req[owner]=0 -> go to GAP, grant=0, gap_cnt=0.
  4. Otherwise stay. The grant persists while req[owner]=1, indefinitely.
- A request dropped before hold_done still sounds until hold_done; there is no early release.
- A lower-priority request never displaces the owner.
- GAP:
  - buzzer_pin=1; gap_cnt increments.
  - req[0]=1 during GAP -> GRANT owner 0 on the next edge; the gap is aborted. This is the only GAP preemption.
  - When gap_cnt = GAP_CYCLES-1: if req != 0, go to GRANT with owner=hp; else go to IDLE.
- Pattern, from phase_cnt (cleared on every owner change):
  - owner 0: tone always on.
  - owner 1: tone on for PERIOD_FAST cycles, off for PERIOD_FAST, repeating; starts on.
  - owner >= 2: same scheme with PERIOD_SLOW.
  - phase_cnt wraps at 2*PERIOD-1.
- buzzer_pin = ~tone in GRANT, 1 otherwise. It is registered from the next-state/phase, so it changes on the same edge as grant.
- Simultaneous requests: lowest index wins. Multiple bits never appear in grant.
- Widths: counters are $clog2(max(MIN_HOLD, GAP_CYCLES, 2*PERIOD_SLOW))+1 bits. Nothing wraps except phase_cnt.

Test Plan:
(Bench parameters: N_REQ=4, MIN_HOLD=8, GAP_CYCLES=4, PERIOD_FAST=2, PERIOD_SLOW=4.)
1. Reset, req=0 -> grant=0000, buzzer_pin=1, busy=0. Then req=0100 at edge k -> grant=0100, owner=2 at edge k+1. buzzer_pin low 4 cycles, high 4, repeating.
2. req[2] pulsed for 1 cycle -> grant held exactly 8 cycles, then GAP 4 cycles with buzzer_pin=1, then IDLE with busy=0.
3. Owner 3 at hold_cnt=2, then req[0] rises -> next edge grant=0001, preempt_pulse=1 for 1 cycle, buzzer_pin=0 continuously.
4. Owner 2 holding with req[2]=1, then req[1] rises at hold_cnt=1 -> switch to owner 1 only after hold_done (hold_cnt reaches 7). preempt_pulse=1 at the switch, no gap. Pattern: 2 low / 2 high.
5. req=1110 together from IDLE -> owner=1. Drop req[1] after 8 cycles -> GAP 4 cycles -> owner=2. Then owner 3 after the next hold plus gap. A lower index never waits for a higher one.
6. req[0] rises in cycle 2 of GAP -> grant=0001 next edge. reset_n=0 mid-GRANT -> grant=0 and buzzer_pin=1 on that edge, even with req held.
